otter_mem_port: RTL

Memory-stage responder for the OTTER pipeline: consumes the per-stage memory controls (read, write, sign, size) plus address and store data, and executes the access on a single-outstanding request/acknowledge data bus. It generates byte enables and lane-replicated store data, extracts and extends load data, and stalls the pipeline until the bus acknowledges. It sits between the memory-stage pipeline register and the data memory/MMIO fabric.

---
 rtl/otter_mem_pkg.sv | 34 +++
 rtl/otter_mem_port_lane.sv | 59 +++++
 rtl/otter_mem_port.sv | 124 ++++++++++++
 3 files changed

// File: rtl/otter_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : otter_mem_pkg
// Purpose  : Shared memory-stage types, opcodes and the alignment helper.
// Revision : 1.0
// ============================================================================
package otter_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;

  // Size code 3 is treated as a word everywhere.
  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/otter_mem_port_lane.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Byte-enable / store-lane replication and load extract/extend.
// Revision : 1.0
// ============================================================================
module mem_lane_align
  import otter_mem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_din,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_din;
    case (i_st_size)
      BYTE: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_din[7:0]}};
      end
      HALF: begin
        o_be    = 4'b0011 << {i_st_off[1], 1'b0};
        o_wdata = {2{i_din[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_ld_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_ld_data = i_rdata;
    case (i_ld_size)
      BYTE:    o_ld_data = {{24{~i_ld_unsigned & w_byte[7]}}, w_byte};
      HALF:    o_ld_data = {{16{~i_ld_unsigned & w_half[15]}}, w_half};
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/otter_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : otter_mem_port
// Purpose  : OTTER memory-stage req/ack bus responder with stall and watchdog.
//            Define MEM_MISALIGN_EN to fault misaligned half/word accesses.
// Revision : 1.0
// ============================================================================
module otter_mem_port
  import otter_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MEM_READ2,
  input  logic        MEM_WRITE2,
  input  logic        MEM_SIGN,
  input  logic [1:0]  MEM_SIZE,
  input  logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_DIN,
  output logic [31:0] MEM_DOUT2,
  output logic        STALL,
  output logic        MEM_FAULT,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_BE,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_ACK,
  input  logic [31:0] BUS_RDATA
);

  localparam int c_WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  mem_state_t        r_state, w_next;
  logic [c_WD_W-1:0] r_wd_cnt;
  logic [1:0]        r_ld_size, r_ld_off;
  logic              r_ld_unsigned;
  logic              w_req, w_misalign, w_issue, w_ack, w_expire;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata, w_ld_data;

  assign w_req = MEM_READ2 | MEM_WRITE2;

`ifdef MEM_MISALIGN_EN
  assign w_misalign = f_misaligned(MEM_SIZE, MEM_ADDR[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue  = (r_state == IDLE) & w_req & ~w_misalign;
  assign w_ack    = (r_state == WAIT) & BUS_ACK;
  // ACK takes priority over a coincident expiry.
  assign w_expire = (TIMEOUT != 0) & (r_state == WAIT) & ~BUS_ACK & (r_wd_cnt == c_WD_LAST);
  assign BUS_REQ  = (r_state == WAIT);

  mem_lane_align u_lane (
    .i_st_size     (MEM_SIZE),
    .i_st_off      (MEM_ADDR[1:0]),
    .i_din         (MEM_DIN),
    .i_ld_size     (r_ld_size),
    .i_ld_off      (r_ld_off),
    .i_ld_unsigned (r_ld_unsigned),
    .i_rdata       (BUS_RDATA),
    .o_be          (w_be),
    .o_wdata       (w_wdata),
    .o_ld_data     (w_ld_data)
  );

  always_comb begin
    w_next = r_state;
    STALL  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          STALL  = 1'b1;
          w_next = w_misalign ? DONE : WAIT;
        end
      end
      WAIT: begin
        STALL = 1'b1;
        if (w_ack || w_expire) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= IDLE;
      r_wd_cnt      <= '0;
      r_ld_size     <= 2'd0;
      r_ld_off      <= 2'd0;
      r_ld_unsigned <= 1'b0;
      BUS_WE        <= 1'b0;
      BUS_ADDR      <= 32'd0;
      BUS_BE        <= 4'd0;
      BUS_WDATA     <= 32'd0;
      MEM_DOUT2     <= 32'd0;
      MEM_FAULT     <= 1'b0;
    end else begin
      r_state   <= w_next;
      MEM_FAULT <= w_expire | ((r_state == IDLE) & w_req & w_misalign);
      if (w_issue) begin
        BUS_WE        <= MEM_WRITE2;
        BUS_ADDR      <= {MEM_ADDR[31:2], 2'b00};
        BUS_BE        <= w_be;
        BUS_WDATA     <= w_wdata;
        r_ld_size     <= MEM_SIZE;
        r_ld_off      <= MEM_ADDR[1:0];
        r_ld_unsigned <= MEM_SIGN;
        r_wd_cnt      <= '0;
      end else if ((r_state == WAIT) && !BUS_ACK) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      // Stores complete on ACK without touching the load result.
      if (w_ack && !BUS_WE) MEM_DOUT2 <= w_ld_data;
    end
  end

endmodule
`default_nettype wire
